// File: rtl/fifo_rr_dispatcher_if.sv
// Signal bundle between the dispatcher, its four input FIFOs and its four output FIFOs.
// The master side is the dispatcher; the slave side is the FIFO fabric around it.
interface fifo_rr_dispatcher_if #(
  parameter int DATA_BITS = 10
);
  logic [DATA_BITS-1:0] data_in0;
  logic [DATA_BITS-1:0] data_in1;
  logic [DATA_BITS-1:0] data_in2;
  logic [DATA_BITS-1:0] data_in3;
  logic [3:0]           empty_in;
  logic [3:0]           full_in;
  logic [3:0]           pop_out;
  logic [3:0]           push_out;
  logic [DATA_BITS-1:0] data_out;

  modport master (
    input  data_in0, data_in1, data_in2, data_in3, empty_in, full_in,
    output pop_out, push_out, data_out
  );

  modport slave (
    output data_in0, data_in1, data_in2, data_in3, empty_in, full_in,
    input  pop_out, push_out, data_out
  );
endinterface

// File: rtl/fifo_rr_dispatcher.sv
// Round-robin pop from four input FIFOs, route each word by its two MSBs to one of
// four output FIFOs over a shared bus, with almost-full stall and sticky error status.
module fifo_rr_dispatcher #(
  parameter int DATA_BITS = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  fifo_rr_dispatcher_if.master bus,
  output logic                 idle_out,
  output logic                 error_out,
  output logic [1:0]           state_out
);

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_ERROR  = 2'd3
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [1:0]           rr_ptr;
  logic [1:0]           winner;
  logic [1:0]           cand;
  logic                 found;
  logic                 pop_any;
  logic                 vld1;
  logic [1:0]           sel_r;
  logic [DATA_BITS-1:0] sel_data;
  logic [1:0]           sel_dest;
  logic [3:0]           full_d1;
  logic [3:0]           full_d2;
  logic                 err_hit;

  always_comb begin
    winner = rr_ptr;
    cand   = rr_ptr;
    found  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cand = rr_ptr + 2'(k);
      if (!found && !bus.empty_in[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  assign pop_any = ((state == ST_IDLE) || (state == ST_ACTIVE)) &&
                   (bus.full_in == 4'h0) && (bus.empty_in != 4'hF);
  assign bus.pop_out = pop_any ? (4'b0001 << winner) : 4'b0000;

  always_comb begin
    case (sel_r)
      2'd0:    sel_data = bus.data_in0;
      2'd1:    sel_data = bus.data_in1;
      2'd2:    sel_data = bus.data_in2;
      default: sel_data = bus.data_in3;
    endcase
  end

  assign sel_dest = sel_data[DATA_BITS-1 -: 2];

  // A word arriving for an output that was already almost-full for the two previous
  // cycles means the fabric outran the in-flight margin.
  assign err_hit = vld1 && full_d1[sel_dest] && full_d2[sel_dest] &&
                   ((state == ST_IDLE) || (state == ST_ACTIVE));

  always_comb begin
    state_next = state;
    case (state)
      ST_RESET:  state_next = ST_IDLE;
      ST_IDLE: begin
        if (err_hit)                    state_next = ST_ERROR;
        else if (bus.empty_in != 4'hF)  state_next = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (err_hit)                                 state_next = ST_ERROR;
        else if ((bus.empty_in == 4'hF) && !vld1)    state_next = ST_IDLE;
      end
      ST_ERROR:  state_next = ST_ERROR;
      default:   state_next = ST_RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_RESET;
      rr_ptr       <= 2'd0;
      sel_r        <= 2'd0;
      vld1         <= 1'b0;
      full_d1      <= 4'h0;
      full_d2      <= 4'h0;
      bus.push_out <= 4'h0;
      bus.data_out <= '0;
      error_out    <= 1'b0;
    end else begin
      state   <= state_next;
      full_d1 <= bus.full_in;
      full_d2 <= full_d1;
      vld1    <= pop_any;
      if (pop_any) begin
        sel_r  <= winner;
        rr_ptr <= winner + 2'd1;
      end
      // Second stage: the popped word is now on its FIFO's read port.
      if (vld1) begin
        bus.data_out <= sel_data;
        bus.push_out <= 4'b0001 << sel_dest;
      end else begin
        bus.push_out <= 4'h0;
      end
      if (err_hit) error_out <= 1'b1;
    end
  end

  assign idle_out  = (state == ST_IDLE);
  assign state_out = state;

endmodule

// File: tb/tb_fifo_rr_dispatcher.sv
// Randomized bench: behavioural input FIFOs feed the dispatcher and a queue-based
// reference predicts pops, routed writes and status every cycle.
module tb_fifo_rr_dispatcher;
  localparam int DATA_BITS = 10;

  typedef logic [DATA_BITS-1:0] word_t;
  typedef struct {
    int    cyc;
    word_t word;
  } wr_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       idle_out;
  logic       error_out;
  logic [1:0] state_out;

  fifo_rr_dispatcher_if #(.DATA_BITS(DATA_BITS)) bus ();

  fifo_rr_dispatcher #(.DATA_BITS(DATA_BITS)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .idle_out  (idle_out),
    .error_out (error_out),
    .state_out (state_out)
  );

  always #5 clk = ~clk;

  int    compared   = 0;
  int    mismatched = 0;
  int    cyc        = 0;
  word_t inq[4][$];
  wr_t   expq[$];
  int    m_state;
  int    m_rr;
  word_t m_last;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic set_data(input int i, input word_t w);
    case (i)
      0:       bus.data_in0 = w;
      1:       bus.data_in1 = w;
      2:       bus.data_in2 = w;
      default: bus.data_in3 = w;
    endcase
  endtask

  function automatic word_t rand_word();
    return word_t'($urandom_range(0, (1 << DATA_BITS) - 1));
  endfunction

  function automatic int pending_words();
    return inq[0].size() + inq[1].size() + inq[2].size() + inq[3].size();
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_rr    = 0;
    m_last  = '0;
    expq.delete();
  endtask

  // One clock cycle: drive inputs, compare every output with the reference, then advance
  // both the input FIFOs and the reference across the edge.
  task automatic applyStimulus(input bit rst, input logic [3:0] full_v);
    logic [3:0] emp;
    logic [3:0] exp_pop;
    logic [3:0] popped;
    logic [3:0] exp_push;
    word_t      exp_data;
    word_t      new_word;
    bit         allowed;
    bit         write_now;
    bit         busy;
    int         win;
    @(negedge clk);
    reset       = rst;
    bus.full_in = full_v;
    for (int i = 0; i < 4; i++) emp[i] = (inq[i].size() == 0);
    bus.empty_in = emp;
    #1;
    allowed = ((m_state == 1) || (m_state == 2)) && (full_v == 4'h0) && (emp != 4'hF);
    win = -1;
    for (int k = 0; k < 4; k++) begin
      if (win < 0 && !emp[(m_rr + k) % 4]) win = (m_rr + k) % 4;
    end
    exp_pop  = allowed ? 4'(1 << win) : 4'h0;
    new_word = allowed ? inq[win][0] : '0;
    write_now = (expq.size() > 0) && (expq[0].cyc == cyc);
    exp_data  = write_now ? expq[0].word : m_last;
    exp_push  = write_now ? 4'(1 << exp_data[DATA_BITS-1 -: 2]) : 4'h0;
    checkOutput("pop_out",   32'(bus.pop_out),  32'(exp_pop));
    checkOutput("push_out",  32'(bus.push_out), 32'(exp_push));
    checkOutput("data_out",  32'(bus.data_out), 32'(exp_data));
    checkOutput("state_out", 32'(state_out),    32'(m_state));
    checkOutput("idle_out",  32'(idle_out),     32'(m_state == 1));
    checkOutput("error_out", 32'(error_out),    32'd0);
    popped = bus.pop_out;
    if (rst) begin
      model_reset();
    end else begin
      busy = 0;
      foreach (expq[j]) if (expq[j].cyc > cyc) busy = 1;
      if (write_now) begin
        m_last = exp_data;
        void'(expq.pop_front());
      end
      if (allowed) begin
        expq.push_back('{cyc: cyc + 2, word: new_word});
        m_rr = (win + 1) % 4;
      end
      case (m_state)
        0:       m_state = 1;
        1:       m_state = (emp != 4'hF) ? 2 : 1;
        2:       m_state = ((emp == 4'hF) && !busy) ? 1 : 2;
        default: m_state = m_state;
      endcase
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 4; i++) begin
      if (popped[i] && inq[i].size() > 0) set_data(i, inq[i].pop_front());
      else set_data(i, rand_word());
    end
  endtask

  task automatic drain_to_idle();
    for (int n = 0; n < 200 && pending_words() > 0; n++) applyStimulus(1'b0, 4'h0);
    checkOutput("drain_words_left", 32'(pending_words()), 32'd0);
    repeat (4) applyStimulus(1'b0, 4'h0);
  endtask

  initial begin
    logic [3:0] full_v;
    int         burst;
    word_t      w;
    word_t      err_word;

    reset        = 1'b1;
    bus.full_in  = 4'h0;
    bus.empty_in = 4'hF;
    for (int i = 0; i < 4; i++) begin
      set_data(i, rand_word());
      repeat (6) inq[i].push_back(rand_word());
    end
    @(posedge clk);
    #1;
    model_reset();

    $display("[TB] reset held with all inputs non-empty");
    repeat (3) applyStimulus(1'b1, 4'h0);

    $display("[TB] round-robin stream then drain to idle");
    drain_to_idle();

    $display("[TB] single word to destination 2");
    w = 10'h205;
    inq[0].push_back(w);
    repeat (6) applyStimulus(1'b0, 4'h0);

    $display("[TB] backpressure on output 2 mid-stream");
    for (int i = 0; i < 4; i++) repeat (8) inq[i].push_back(rand_word());
    repeat (4) applyStimulus(1'b0, 4'h0);
    repeat (5) applyStimulus(1'b0, 4'b0100);
    drain_to_idle();

    $display("[TB] randomized traffic, backpressure and resets");
    burst  = 0;
    full_v = 4'h0;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 2) == 0) inq[$urandom_range(0, 3)].push_back(rand_word());
      if (burst == 0 && $urandom_range(0, 9) == 0) begin
        burst  = $urandom_range(1, 5);
        full_v = 4'($urandom_range(1, 15));
      end
      if (burst > 0) burst--;
      else full_v = 4'h0;
      applyStimulus($urandom_range(0, 99) == 0, full_v);
    end
    drain_to_idle();

    $display("[TB] overflow error with output 1 held almost-full");
    repeat (3) applyStimulus(1'b0, 4'b0010);
    @(negedge clk);
    err_word = {2'b01, 8'($urandom_range(0, 255))};
    for (int i = 0; i < 4; i++) set_data(i, err_word);
    force dut.vld1 = 1'b1;
    @(posedge clk);
    #1;
    release dut.vld1;
    checkOutput("err_error_out", 32'(error_out),    32'd1);
    checkOutput("err_state_out", 32'(state_out),    32'd3);
    checkOutput("err_push_out",  32'(bus.push_out), 32'h2);
    checkOutput("err_data_out",  32'(bus.data_out), 32'(err_word));
    checkOutput("err_idle_out",  32'(idle_out),     32'd0);
    for (int i = 0; i < 4; i++) inq[i].push_back(rand_word());
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      bus.full_in  = 4'h0;
      bus.empty_in = 4'h0;
      #1;
      checkOutput("err_pop_blocked", 32'(bus.pop_out), 32'd0);
      checkOutput("err_state_hold",  32'(state_out),   32'd3);
      checkOutput("err_sticky",      32'(error_out),   32'd1);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst_error_out", 32'(error_out),    32'd0);
    checkOutput("rst_state_out", 32'(state_out),    32'd0);
    checkOutput("rst_push_out",  32'(bus.push_out), 32'd0);
    checkOutput("rst_data_out",  32'(bus.data_out), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fifo_rr_dispatcher.md
Name: fifo_rr_dispatcher

Overview:
- Sits directly downstream of four parallel input FIFOs and upstream of four output FIFOs.
- Pops words from the non-empty input FIFOs in round-robin order.
- Routes each word to one of four output FIFOs, selected by the two MSBs of the word, using one shared data bus and one push strobe per output.
- Stalls whenever any output FIFO reports almost-full, and tracks idle/active/error status for the system controller.

Parameters:
DATA_BITS, 10, word width; bits [DATA_BITS-1:DATA_BITS-2] are the destination index (0..3)

Ports:
clk  input  1  single clock; all state updates on posedge
reset  input  1  synchronous, active-high reset
data_in0..data_in3  input  DATA_BITS each  read data of input FIFOs 0..3, valid the cycle after the matching pop
empty_in  input  4  almost-empty flags of input FIFOs (bit i = FIFO i)
full_in  input  4  almost-full flags of output FIFOs (bit j = FIFO j)
pop_out  input-FIFO read strobes  output  4  combinational, at most one bit high
push_out  output  4  registered write strobes to output FIFOs, at most one bit high
data_out  output  DATA_BITS  registered shared write data for all output FIFOs
idle_out  output  1  high in IDLE
error_out  output  1  sticky error flag
state_out  output  2  current FSM state (RESET=0, IDLE=1, ACTIVE=2, ERROR=3)

Behaviour:
- Reset (reset=1 at posedge):
  - state=RESET, rr_ptr=0, in-flight flags cleared.
  - push_out=0, data_out=0, error_out=0, idle_out=0.
  - pop_out forced to 0 combinationally while in RESET.
  - Reset mid-transfer discards in-flight words; no push is issued for them.
- FSM:
  - RESET -> IDLE on the first posedge with reset=0.
  - IDLE -> ACTIVE when any empty_in bit is 0.
  - ACTIVE -> IDLE when empty_in=4'hF and no pop/push is in flight.
  - ACTIVE/IDLE -> ERROR on an error condition.
  - ERROR holds until reset.
  - idle_out=1 only in IDLE.
- Pop enable (combinational, cycle N): pop allowed only when all of the following hold:
  - state is IDLE or ACTIVE;
  - full_in==4'h0;
  - at least one empty_in bit is 0.
- Grant:
  - The winner is the first input with empty_in[i]==0, scanning rr_ptr, rr_ptr+1, ... mod 4.
  - pop_out[winner]=1 in cycle N.
  - rr_ptr <= winner+1 (mod 4, 2-bit wrap) at the end of N.
  - With no pop, rr_ptr holds.
- Pipeline (pop-to-push latency = 2 cycles):
  - Cycle N: pop_out[i]=1, and sel_r<=i, vld1<=1 are registered.
  - Cycle N+1: data_in[sel_r] is valid; data_out<=data_in[sel_r] and push_out<=onehot(data_in[sel_r][MSB:MSB-1]) are registered.
  - Cycle N+2: push_out/data_out are presented; the output FIFO writes on that edge.
  - Back-to-back pops (one per cycle) are sustained while the enable holds; throughput is 1 word/clk.
- In cycles with no valid word, push_out=0 and data_out holds its last value.
- Flow-control margin:
  - Up to 2 words can be in flight when full_in rises.
  - Output FIFO high_limit must leave at least 3 free slots; this is a system requirement.
- Error conditions (checked at the posedge, registered):
  - A push is being registered to destination j while full_in[j]==1 and that output FIFO is fully full (signalled by full_in[j]==1 for 3 consecutive cycles with a push to j in each).
  - Simpler implemented form: a push to j occurs while full_in[j] has been high for ≥2 prior cycles.
  - On error: error_out<=1, state<=ERROR, the offending push is still issued, and no further pops occur.
- Simultaneous events:
  - full_in rising in the same cycle as a candidate pop blocks that pop, because the enable is combinational on the current full_in.
  - Multiple non-empty inputs are resolved only by rr_ptr order.

Test Plan:
1. Reset: reset=1 for 3 clk with empty_in=4'h0 -> pop_out=0, push_out=0, data_out=0, error_out=0, state_out=0; first clk after release gives state_out=1, idle_out=1.
2. Single word: empty_in=4'hE, data_in0=10'b10_00000101 one cycle after the pop -> pop_out=4'b0001 at N, push_out=4'b0100 and data_out=10'h205 at N+2, rr_ptr=1.
3. Round-robin fairness: all four inputs non-empty for 8 cycles with full_in=0 -> pop_out sequence 1,2,4,8,1,2,4,8; 8 pushes, routed according to each word's MSBs.
4. Backpressure: full_in[2] raised in cycle 5 of a continuous stream -> pop_out=0 from cycle 5; at most 2 trailing pushes; resumes on the first cycle after full_in=0 at the preserved rr_ptr.
5. Idle return: drain all inputs (empty_in=4'hF) -> state ACTIVE->IDLE two cycles after the last pop; idle_out=1.
6. Error: hold full_in[1]=1 and force an in-flight word with dest=1 -> error_out=1, state_out=3, pop_out stays 0 until reset=1; reset clears error_out to 0.
